hilo_acc_file: RTL

HILO_ACC_FILE -- requirements
Module: hilo_acc_file

---
 rtl/hilo_acc_pkg.sv | 19 +
 rtl/hilo_acc_stage.sv | 64 ++++++
 rtl/hilo_acc_file.sv | 103 ++++++++++
 3 files changed

// File: rtl/hilo_acc_pkg.sv
// Shared definitions for the HI/LO accumulator register file:
// op codes, default data width and the request-decoding helper.
package hilo_acc_pkg;

    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        OP_WR   = 2'b00,
        OP_MADD = 2'b01,
        OP_MSUB = 2'b10,
        OP_RSV  = 2'b11
    } acc_op_e;

    // A reserved op code behaves as if the port made no request at all.
    function automatic logic op_is_req(input logic [1:0] op);
        return op != OP_RSV;
    endfunction

endpackage

// File: rtl/hilo_acc_stage.sv
// Two-stage add/sub datapath for MADD/MSUB on the {HI,LO} pair.
// Stage 1 forms the low half and its carry/borrow. Stage 2 forms the
// high half from the current HI; the caller decides whether to commit.
module hilo_acc_stage
    import hilo_acc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  acc_op_e               i_op,
    input  logic [DATA_W-1:0]     i_lo,
    input  logic [DATA_W-1:0]     i_hi,
    input  logic [2*DATA_W-1:0]   i_acc,
    output logic                  o_busy,
    output logic [DATA_W-1:0]     o_hi_new,
    output logic [DATA_W-1:0]     o_lo_new
);

    logic [DATA_W:0]   w_low_ext_p0;
    logic              r_vld_p1;
    logic              r_sub_p1;
    logic              r_cy_p1;
    logic [DATA_W-1:0] r_low_p1;
    logic [DATA_W-1:0] r_acc_hi_p1;
    logic [DATA_W-1:0] w_cy_ext_p1;

    // Stage 1: low-half add/sub; the extra top bit is carry (add) or borrow (sub)
    always_comb begin
        w_low_ext_p0 = '0;
        if (i_op == OP_MSUB)
            w_low_ext_p0 = {1'b0, i_lo} - {1'b0, i_acc[DATA_W-1:0]};
        else
            w_low_ext_p0 = {1'b0, i_lo} + {1'b0, i_acc[DATA_W-1:0]};
    end

    // Stage 1 registers: captured only when an accumulate is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1    <= 1'b0;
            r_sub_p1    <= 1'b0;
            r_cy_p1     <= 1'b0;
            r_low_p1    <= '0;
            r_acc_hi_p1 <= '0;
        end else begin
            r_vld_p1 <= i_start;
            if (i_start) begin
                r_sub_p1    <= (i_op == OP_MSUB);
                r_cy_p1     <= w_low_ext_p0[DATA_W];
                r_low_p1    <= w_low_ext_p0[DATA_W-1:0];
                r_acc_hi_p1 <= i_acc[2*DATA_W-1:DATA_W];
            end
        end
    end

    // Stage 2: high half folds in the carry/borrow, wrapping mod 2^DATA_W
    assign w_cy_ext_p1 = {{(DATA_W-1){1'b0}}, r_cy_p1};
    assign o_hi_new    = r_sub_p1 ? (i_hi - r_acc_hi_p1 - w_cy_ext_p1)
                                  : (i_hi + r_acc_hi_p1 + w_cy_ext_p1);
    assign o_lo_new    = r_low_p1;
    assign o_busy      = r_vld_p1;

endmodule

// File: rtl/hilo_acc_file.sv
// HI/LO accumulator register file with NPORT issue slots.
// Highest-index valid port wins; WR updates directly, MADD/MSUB go
// through the two-stage datapath and commit one edge later unless flushed.
module hilo_acc_file
    import hilo_acc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NPORT  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NPORT-1:0]            we_i,
    input  logic [2*NPORT-1:0]          op_i,
    input  logic [NPORT-1:0]            hi_we_i,
    input  logic [NPORT-1:0]            lo_we_i,
    input  logic [NPORT*DATA_W-1:0]     hi_i,
    input  logic [NPORT*DATA_W-1:0]     lo_i,
    input  logic [NPORT*2*DATA_W-1:0]   acc_i,
    input  logic                        flush_i,
    output logic [DATA_W-1:0]           hi_o,
    output logic [DATA_W-1:0]           lo_o,
    output logic                        busy_o
);

    logic                 w_win_vld;
    acc_op_e              w_win_op;
    logic                 w_win_hwe;
    logic                 w_win_lwe;
    logic [DATA_W-1:0]    w_win_hi;
    logic [DATA_W-1:0]    w_win_lo;
    logic [2*DATA_W-1:0]  w_win_acc;
    logic                 w_accept;
    logic                 w_wr;
    logic                 w_start;
    logic                 w_commit;
    logic                 w_busy;
    logic [DATA_W-1:0]    w_hi_new;
    logic [DATA_W-1:0]    w_lo_new;
    logic [DATA_W-1:0]    r_hi;
    logic [DATA_W-1:0]    r_lo;

    // Arbitration: ascending scan so the youngest (highest-index) valid port wins
    always_comb begin
        w_win_vld = 1'b0;
        w_win_op  = OP_WR;
        w_win_hwe = 1'b0;
        w_win_lwe = 1'b0;
        w_win_hi  = '0;
        w_win_lo  = '0;
        w_win_acc = '0;
        for (int k = 0; k < NPORT; k++) begin
            if (we_i[k] && op_is_req(op_i[2*k +: 2])) begin
                w_win_vld = 1'b1;
                w_win_op  = acc_op_e'(op_i[2*k +: 2]);
                w_win_hwe = hi_we_i[k];
                w_win_lwe = lo_we_i[k];
                w_win_hi  = hi_i[k*DATA_W +: DATA_W];
                w_win_lo  = lo_i[k*DATA_W +: DATA_W];
                w_win_acc = acc_i[k*2*DATA_W +: 2*DATA_W];
            end
        end
    end

    // Requests are dropped outright while busy or flushing; nothing is queued
    assign w_accept = w_win_vld & ~w_busy & ~flush_i;
    assign w_wr     = w_accept & (w_win_op == OP_WR);
    assign w_start  = w_accept & (w_win_op != OP_WR);
    assign w_commit = w_busy & ~flush_i;

    hilo_acc_stage #(
        .DATA_W (DATA_W)
    ) u_stage (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_start),
        .i_op     (w_win_op),
        .i_lo     (r_lo),
        .i_hi     (r_hi),
        .i_acc    (w_win_acc),
        .o_busy   (w_busy),
        .o_hi_new (w_hi_new),
        .o_lo_new (w_lo_new)
    );

    // Architectural HI/LO: stage-2 commit or per-field WR (mutually exclusive)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_commit) begin
            r_hi <= w_hi_new;
            r_lo <= w_lo_new;
        end else if (w_wr) begin
            if (w_win_hwe) r_hi <= w_win_hi;
            if (w_win_lwe) r_lo <= w_win_lo;
        end
    end

    assign hi_o   = r_hi;
    assign lo_o   = r_lo;
    assign busy_o = w_busy;

endmodule
